countdown_timer: RTL and testbench

//  Egg-timer countdown core. Consumes the divided square-wave clock from the clock divider as a
//  1 Hz timebase, synchronises it into the clk domain, and counts a loaded MM:SS value down to
//  00:00 in BCD. Then raises an alarm for a fixed number of seconds. Sits between the divider
//  and the display/buzzer drivers.

---
 rtl/countdown_timer_pkg.sv | 56 +++++
 rtl/countdown_timer_slow_clk_tick.sv | 26 ++
 rtl/countdown_timer.sv | 114 +++++++++++
 tb/tb_countdown_timer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the egg-timer countdown core: state encoding,
// BCD digit limits, load sanitising and saturating MM:SS decrement.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] SECT_MAX  = 4'd5;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
  } mmss_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic mmss_t sanitise(input logic [7:0] m, input logic [7:0] s);
    mmss_t r;
    r.min = {clamp_digit(m[7:4], DIGIT_MAX), clamp_digit(m[3:0], DIGIT_MAX)};
    r.sec = {clamp_digit(s[7:4], SECT_MAX), clamp_digit(s[3:0], DIGIT_MAX)};
    return r;
  endfunction

  // Borrow ripples sec ones -> sec tens -> min ones -> min tens; 00:00 holds.
  function automatic mmss_t bcd_dec(input mmss_t v);
    mmss_t r;
    r = v;
    if (v != '0) begin
      if (v.sec[3:0] != 4'd0) begin
        r.sec[3:0] = v.sec[3:0] - 4'd1;
      end else begin
        r.sec[3:0] = DIGIT_MAX;
        if (v.sec[7:4] != 4'd0) begin
          r.sec[7:4] = v.sec[7:4] - 4'd1;
        end else begin
          r.sec[7:4] = SECT_MAX;
          if (v.min[3:0] != 4'd0) begin
            r.min[3:0] = v.min[3:0] - 4'd1;
          end else begin
            r.min[3:0] = DIGIT_MAX;
            r.min[7:4] = v.min[7:4] - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_slow_clk_tick.sv
// Brings the divided slowClk into the clk domain and emits a one-cycle tick
// per rising edge (tick is combinational from the last two flops).
module slow_clk_tick (
  input  logic clk,
  input  logic reset,
  input  logic slowClk,
  output logic tick
);

  logic ff1, ff2, ff3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
      ff3 <= 1'b0;
    end else begin
      ff1 <= slowClk;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign tick = ff2 & ~ff3;

endmodule

// File: rtl/countdown_timer.sv
// Egg-timer core: counts a loaded BCD MM:SS down on each second tick, then
// holds the alarm for ALARM_SECS ticks before returning to idle.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slowClk,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [7:0] loadMin,
  input  logic [7:0] loadSec,
  output logic [7:0] minBcd,
  output logic [7:0] secBcd,
  output logic       running,
  output logic       alarm,
  output logic       donePulse
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

  state_t     state, state_nx;
  mmss_t      cur, cur_nx, dec;
  logic [7:0] alarm_cnt, alarm_cnt_nx;
  logic       done_nx;
  logic       tick;

  slow_clk_tick u_tick (
    .clk    (clk),
    .reset  (reset),
    .slowClk(slowClk),
    .tick   (tick)
  );

  assign dec    = bcd_dec(cur);
  assign minBcd = cur.min;
  assign secBcd = cur.sec;

  // Next-state logic; stop outranks start, start outranks load.
  always_comb begin
    state_nx     = state;
    cur_nx       = cur;
    alarm_cnt_nx = alarm_cnt;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (!stop) begin
          if (start) begin
            if (cur != '0) state_nx = RUN;
          end else if (load) begin
            cur_nx = sanitise(loadMin, loadSec);
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = PAUSE;
        end else if (tick) begin
          cur_nx = dec;
          if (dec == '0) begin
            state_nx = ALARM;
            done_nx  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (!stop) begin
          if (start) begin
            state_nx = RUN;
          end else if (load) begin
            cur_nx = sanitise(loadMin, loadSec);
          end
        end
      end
      ALARM: begin
        if (stop) begin
          state_nx     = IDLE;
          alarm_cnt_nx = 8'd0;
        end else if (tick) begin
          if (alarm_cnt == ALARM_LAST) begin
            state_nx     = IDLE;
            alarm_cnt_nx = 8'd0;
          end else begin
            alarm_cnt_nx = alarm_cnt + 8'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs follow the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      alarm_cnt <= 8'd0;
      running   <= 1'b0;
      alarm     <= 1'b0;
      donePulse <= 1'b0;
    end else begin
      state     <= state_nx;
      cur       <= cur_nx;
      alarm_cnt <= alarm_cnt_nx;
      running   <= (state_nx == RUN);
      alarm     <= (state_nx == ALARM);
      donePulse <= done_nx;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: countdown, alarm, pause, clamp,
// event priority, tick latency and asynchronous reset.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, slowClk, start, stop, load;
  logic [7:0] loadMin, loadSec;
  logic [7:0] minBcd, secBcd;
  logic       running, alarm, donePulse;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #10 clk = ~clk;

  countdown_timer #(.ALARM_SECS(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .slowClk  (slowClk),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .loadMin  (loadMin),
    .loadSec  (loadSec),
    .minBcd   (minBcd),
    .secBcd   (secBcd),
    .running  (running),
    .alarm    (alarm),
    .donePulse(donePulse)
  );

  assign obs = {minBcd, secBcd, running, alarm};

  task automatic step();
    @(posedge clk);
    #1;
    done_cnt += int'(donePulse);
  endtask

  task automatic pulse(input logic s, input logic t, input logic l);
    start = s; stop = t; load = l;
    step();
    start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      slowClk = 1'b1;
      repeat (3) step();
      slowClk = 1'b0;
      repeat (3) step();
    end
  endtask

  task automatic load_val(input logic [7:0] m, input logic [7:0] s);
    loadMin = m; loadSec = s;
    pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({obs, donePulse} !== 19'd0) begin
      errors++; $display("FAIL reset_state got %h exp %h", {obs, donePulse}, 19'd0);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_full_minute();
    load_val(8'h01, 8'h00);
    checks++;
    if (obs !== {8'h01, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL load_0100 got %h exp %h", obs, {8'h01, 8'h00, 1'b0, 1'b0});
    end
    pulse(1'b1, 1'b0, 1'b0);
    done_cnt = 0;
    ticks(1);
    checks++;
    if (obs !== {8'h00, 8'h59, 1'b1, 1'b0}) begin
      errors++; $display("FAIL first_tick got %h exp %h", obs, {8'h00, 8'h59, 1'b1, 1'b0});
    end
    ticks(58);
    checks++;
    if (obs !== {8'h00, 8'h01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tick_59 got %h exp %h", obs, {8'h00, 8'h01, 1'b1, 1'b0});
    end
    ticks(1);
    checks++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reach_zero got %h exp %h", obs, {8'h00, 8'h00, 1'b0, 1'b1});
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL done_pulse_count got %0d exp 1", done_cnt);
    end
  endtask

  task automatic test_alarm();
    ticks(9);
    checks++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL alarm_after_9 got %h exp %h", obs, {8'h00, 8'h00, 1'b0, 1'b1});
    end
    ticks(1);
    checks++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL alarm_after_10 got %h exp %h", obs, {8'h00, 8'h00, 1'b0, 1'b0});
    end
  endtask

  task automatic test_pause();
    load_val(8'h00, 8'h10);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(3);
    checks++;
    if (obs !== {8'h00, 8'h07, 1'b1, 1'b0}) begin
      errors++; $display("FAIL run_3_ticks got %h exp %h", obs, {8'h00, 8'h07, 1'b1, 1'b0});
    end
    pulse(1'b0, 1'b1, 1'b0);
    ticks(5);
    checks++;
    if (obs !== {8'h00, 8'h07, 1'b0, 1'b0}) begin
      errors++; $display("FAIL paused_hold got %h exp %h", obs, {8'h00, 8'h07, 1'b0, 1'b0});
    end
    pulse(1'b1, 1'b0, 1'b0);
    ticks(1);
    checks++;
    if (obs !== {8'h00, 8'h06, 1'b1, 1'b0}) begin
      errors++; $display("FAIL resume_tick got %h exp %h", obs, {8'h00, 8'h06, 1'b1, 1'b0});
    end
  endtask

  task automatic test_start_stop_same();
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    ticks(1);
    checks++;
    if (obs !== {8'h00, 8'h06, 1'b0, 1'b0}) begin
      errors++; $display("FAIL start_stop_pause got %h exp %h", obs, {8'h00, 8'h06, 1'b0, 1'b0});
    end
  endtask

  task automatic test_tick_stop();
    pulse(1'b1, 1'b0, 1'b0);
    slowClk = 1'b1;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (obs !== {8'h00, 8'h06, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tick_with_stop got %h exp %h", obs, {8'h00, 8'h06, 1'b0, 1'b0});
    end
    slowClk = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_latency();
    pulse(1'b1, 1'b0, 1'b0);
    slowClk = 1'b1;
    step();
    step();
    checks++;
    if (secBcd !== 8'h06) begin
      errors++; $display("FAIL latency_k1 got %h exp %h", secBcd, 8'h06);
    end
    step();
    checks++;
    if (secBcd !== 8'h05) begin
      errors++; $display("FAIL latency_k2 got %h exp %h", secBcd, 8'h05);
    end
    slowClk = 1'b0;
    repeat (3) step();
    pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clamp();
    load_val(8'hA3, 8'h7C);
    checks++;
    if (obs !== {8'h93, 8'h59, 1'b0, 1'b0}) begin
      errors++; $display("FAIL clamp_load got %h exp %h", obs, {8'h93, 8'h59, 1'b0, 1'b0});
    end
    pulse(1'b1, 1'b0, 1'b0);
    load_val(8'h12, 8'h34);
    checks++;
    if (obs !== {8'h93, 8'h59, 1'b1, 1'b0}) begin
      errors++; $display("FAIL load_in_run got %h exp %h", obs, {8'h93, 8'h59, 1'b1, 1'b0});
    end
    pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_zero_start();
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    ticks(1);
    checks++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL start_at_zero got %h exp %h", obs, {8'h00, 8'h00, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid_run();
    load_val(8'h05, 8'h17);
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== {8'h05, 8'h17, 1'b1, 1'b0}) begin
      errors++; $display("FAIL run_0517 got %h exp %h", obs, {8'h05, 8'h17, 1'b1, 1'b0});
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset got %h exp %h", obs, {8'h00, 8'h00, 1'b0, 1'b0});
    end
    step();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL post_reset_idle got %h exp %h", obs, {8'h00, 8'h00, 1'b0, 1'b0});
    end
  endtask

  initial begin
    reset = 1'b1; slowClk = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    loadMin = 8'h00; loadSec = 8'h00;
    test_reset();
    test_full_minute();
    test_alarm();
    test_pause();
    test_start_stop_same();
    test_tick_stop();
    test_latency();
    test_clamp();
    test_zero_start();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
